// File: rtl/exp_operand_loader.sv
// Operand loader for the 512-bit modexp core: buffers x/y from a 32-bit host
// stream, then pulses core_rst and streams eight 128-bit slices. Option macro: LOADER_ZEROIZE_EN.
module exp_operand_loader #(
  parameter int unsigned HOST_W   = 32,
  parameter int unsigned BUS_W    = 128,
  parameter int unsigned OP_W     = 512,
  parameter int unsigned RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HOST_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              flush,
  input  logic              start,
  output logic              core_rst,
  output logic [BUS_W-1:0]  bus_out,
  output logic              full,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORDS  = 2 * OP_W / HOST_W;
  localparam int unsigned SLICES = 2 * OP_W / BUS_W;
  localparam int unsigned WP_W   = $clog2(WORDS + 1);
  localparam int unsigned SW     = $clog2(SLICES);
  localparam int unsigned CW     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [WP_W-1:0] WP_FULL = WP_W'(WORDS);

  typedef enum logic [1:0] {LOAD, CRST, STREAM, FIN} state_t;

  state_t             state_q, state_d;
  logic [WP_W-1:0]    wp_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      s_q, s_d;
  logic [2*OP_W-1:0]  buf_q;
  logic [BUS_W-1:0]   slice_d;
  logic               xfer;

  assign host_ready = (state_q == LOAD) && (wp_q < WP_FULL);
  assign full       = (wp_q == WP_FULL);
  assign busy       = (state_q == CRST) || (state_q == STREAM);
  assign xfer       = host_valid && host_ready && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    case (state_q)
      LOAD: begin
        if (start && full) begin
          state_d = CRST;
          cnt_d   = '0;
        end
      end
      CRST: begin
        if (cnt_q == CW'(RST_HOLD - 1)) begin
          state_d = STREAM;
          s_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STREAM: begin
        if (s_q == SW'(SLICES - 1)) state_d = FIN;
        else                        s_d = s_q + SW'(1);
      end
      FIN:     state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Slice for the next cycle, so bus_out is registered yet lands in the cycle the core samples it.
  always_comb begin
    slice_d = '0;
    for (int unsigned k = 0; k < SLICES; k++) begin
      if (s_d == SW'(k)) slice_d = buf_q[k*BUS_W +: BUS_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      s_q      <= '0;
      core_rst <= 1'b1;
      bus_out  <= '0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      if (state_d == CRST)        core_rst <= 1'b1;
      else if (state_d == STREAM) core_rst <= 1'b0;
      bus_out <= (state_d == STREAM) ? slice_d : '0;
      done    <= (state_d == FIN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      buf_q <= '0;
    end else begin
      if ((state_q == LOAD) && flush) begin
        wp_q <= '0;
      end else if (xfer) begin
        wp_q <= wp_q + WP_W'(1);
        for (int unsigned k = 0; k < WORDS; k++) begin
          if (wp_q == WP_W'(k)) buf_q[k*HOST_W +: HOST_W] <= host_data;
        end
      end
`ifdef LOADER_ZEROIZE_EN
      if (state_q == FIN) begin
        wp_q  <= '0;
        buf_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_exp_operand_loader.sv
// Directed bench for exp_operand_loader: load, stream timing, core capture model,
// start/flush corner cases, mid-stream reset and post-done behaviour.
module tb_exp_operand_loader;

  localparam int unsigned RST_HOLD = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  host_data;
  logic         host_valid;
  logic         host_ready;
  logic         flush;
  logic         start;
  logic         core_rst;
  logic [127:0] bus_out;
  logic         full;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1023:0] model;

  exp_operand_loader #(
    .HOST_W(32), .BUS_W(128), .OP_W(512), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .flush(flush), .start(start), .core_rst(core_rst),
    .bus_out(bus_out), .full(full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Core model: after start, wait for core_rst low, then load slice i on each following edge.
  task automatic stream_capture(output logic [1023:0] got, output bit timed_out, output logic done_seen);
    int n;
    got = '0;
    timed_out = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (core_rst === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (core_rst !== 1'b0) timed_out = 1'b1;
    got[127:0] = bus_out;
    for (int i = 1; i < 8; i++) begin
      tick();
      got[i*128 +: 128] = bus_out;
    end
    tick();
    done_seen = done;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; host_data = '0; host_valid = 1'b0; flush = 1'b0; start = 1'b0;
    #3;
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    n_checks++; if (bus_out !== 128'h0) begin n_fail++; $display("FAIL reset_bus_out: got %h expected 0", bus_out); end
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_ready: got %b expected 1", host_ready); end
    n_checks++; if ({full, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {full, busy, done}); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_release_core_rst: got %b expected 1", core_rst); end
  endtask

  task automatic test_load;
    host_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      host_data = 32'(i);
      model[i*32 +: 32] = 32'(i);
      n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_w%0d: got %b expected 1", i, host_ready); end
      tick();
    end
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_after32: got %b expected 0", host_ready); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL load_full: got %b expected 1", full); end
    host_data = 32'hDEAD_BEEF;
    tick();
    host_valid = 1'b0;
    n_checks++; if (full !== 1'b1 || host_ready !== 1'b0) begin n_fail++; $display("FAIL load_33rd: got full=%b ready=%b expected full=1 ready=0", full, host_ready); end
  endtask

  task automatic test_stream;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (core_rst !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL stream_t1: got core_rst=%b busy=%b expected 1 1", core_rst, busy); end
    tick();
    n_checks++; if (core_rst !== 1'b1 || bus_out !== 128'h0) begin n_fail++; $display("FAIL stream_t2: got core_rst=%b bus=%h expected 1 0", core_rst, bus_out); end
    tick();
    n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL stream_s0_core_rst: got %b expected 0", core_rst); end
    n_checks++; if (bus_out !== 128'h00000003_00000002_00000001_00000000) begin n_fail++; $display("FAIL stream_s0: got %h expected 00000003000000020000000100000000", bus_out); end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_checks++; if (bus_out !== model[i*128 +: 128]) begin n_fail++; $display("FAIL stream_s%0d: got %h expected %h", i, bus_out, model[i*128 +: 128]); end
    end
    n_checks++; if (bus_out !== 128'h0000001F_0000001E_0000001D_0000001C) begin n_fail++; $display("FAIL stream_s7: got %h expected 0000001f0000001e0000001d0000001c", bus_out); end
    tick();
    n_checks++; if (done !== 1'b1 || bus_out !== 128'h0) begin n_fail++; $display("FAIL stream_done: got done=%b bus=%h expected 1 0", done, bus_out); end
    n_checks++; if (busy !== 1'b0 || core_rst !== 1'b0) begin n_fail++; $display("FAIL stream_fin: got busy=%b core_rst=%b expected 0 0", busy, core_rst); end
    tick();
    n_checks++; if (done !== 1'b0 || host_ready !== !full) begin n_fail++; $display("FAIL stream_after: got done=%b ready=%b expected done=0 ready=%b", done, host_ready, !full); end
  endtask

  task automatic test_replay;
    logic [1023:0] got;
    bit            to;
    logic          ds;
`ifdef LOADER_ZEROIZE_EN
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL replay_zeroize_full: got %b expected 0", full); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0 || core_rst !== 1'b0 || bus_out !== 128'h0) begin n_fail++; $display("FAIL replay_zeroize_start: got busy=%b core_rst=%b bus=%h expected 0 0 0", busy, core_rst, bus_out); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL replay_zeroize_idle: got %b expected 0", busy); end
`else
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL replay_full: got %b expected 1", full); end
    stream_capture(got, to, ds);
    n_checks++; if (to) begin n_fail++; $display("FAIL replay_timeout: got timeout expected core_rst low"); end
    n_checks++; if (got !== model) begin n_fail++; $display("FAIL replay_data: got x=%h expected x=%h", got[511:0], model[511:0]); end
    n_checks++; if (ds !== 1'b1) begin n_fail++; $display("FAIL replay_done: got %b expected 1", ds); end
`endif
  endtask

  task automatic test_partial_start;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (full !== 1'b0 || host_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ptr: got full=%b ready=%b expected 0 1", full, host_ready); end
    host_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      host_data = 32'(100 + i);
      tick();
    end
    host_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0 || core_rst !== 1'b0) begin n_fail++; $display("FAIL partial_start: got busy=%b core_rst=%b expected 0 0", busy, core_rst); end
    n_checks++; if (host_ready !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL partial_ready: got ready=%b full=%b expected 1 0", host_ready, full); end
    tick();
    n_checks++; if (busy !== 1'b0 || bus_out !== 128'h0) begin n_fail++; $display("FAIL partial_idle: got busy=%b bus=%h expected 0 0", busy, bus_out); end
    // flush wins over a simultaneous transfer: 31 more words must not fill the buffer
    host_valid = 1'b1;
    host_data  = 32'h0000_0BAD;
    flush      = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 31; i++) begin
      host_data = 32'(200 + i);
      tick();
    end
    n_checks++; if (full !== 1'b0 || host_ready !== 1'b1) begin n_fail++; $display("FAIL flush_drop_31: got full=%b ready=%b expected 0 1", full, host_ready); end
    tick();
    host_valid = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL flush_drop_32: got %b expected 1", full); end
  endtask

  task automatic test_random;
    logic [1023:0] got;
    bit            to;
    logic          ds;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    host_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      host_data = $urandom();
      model[i*32 +: 32] = host_data;
      tick();
    end
    host_valid = 1'b0;
    stream_capture(got, to, ds);
    n_checks++; if (to) begin n_fail++; $display("FAIL random_timeout: got timeout expected core_rst low"); end
    n_checks++; if (got[511:0] !== model[511:0]) begin n_fail++; $display("FAIL random_x: got %h expected %h", got[511:0], model[511:0]); end
    n_checks++; if (got[1023:512] !== model[1023:512]) begin n_fail++; $display("FAIL random_y: got %h expected %h", got[1023:512], model[1023:512]); end
    n_checks++; if (ds !== 1'b1) begin n_fail++; $display("FAIL random_done: got %b expected 1", ds); end
  endtask

  task automatic test_reset_midstream;
    // reload so the buffer is full in both build variants
    flush = 1'b1;
    tick();
    flush = 1'b0;
    host_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      host_data = 32'hA5A5_0000 + 32'(i);
      model[i*32 +: 32] = host_data;
      tick();
    end
    host_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RST_HOLD + 4; i++) tick();
    n_checks++; if (bus_out !== model[4*128 +: 128]) begin n_fail++; $display("FAIL midrst_s4: got %h expected %h", bus_out, model[4*128 +: 128]); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (core_rst !== 1'b1 || bus_out !== 128'h0) begin n_fail++; $display("FAIL midrst_async: got core_rst=%b bus=%h expected 1 0", core_rst, bus_out); end
    n_checks++; if (busy !== 1'b0 || full !== 1'b0 || host_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state: got busy=%b full=%b ready=%b expected 0 0 1", busy, full, host_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    n_checks++; if (host_ready !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_release: got ready=%b full=%b busy=%b core_rst=%b expected 1 0 0 1", host_ready, full, busy, core_rst); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_replay();
    test_partial_start();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
